// File: rtl/cpu_keys_in.sv
// Input PIO slave: synchronises and debounces WIDTH key/switch pins, exposes the debounced level,
// latches edges in a write-one-to-clear register and drives a maskable level interrupt.
module cpu_keys_in #(
    parameter int                 WIDTH           = 4,
    parameter int                 DEBOUNCE_CYCLES = 50000,
    parameter bit                 EDGE_FALLING    = 1'b1,
    parameter logic [WIDTH-1:0]   RESET_LEVEL     = {WIDTH{1'b1}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic [WIDTH-1:0]  in_port,
    output logic              irq
);

    localparam int            CW   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] level_q, level_d;
    logic [WIDTH-1:0] level_prev_q;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] ecap_q, ecap_d;
    logic [WIDTH-1:0] edge_set;
    logic             irq_q, irq_d;
    logic             wr_en;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];

    // Per-bit debounce: the count only advances while the synchronised pin disagrees with the
    // accepted level, so any return to the accepted level restarts it from zero.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_debounce
        logic differ;
        logic at_term;

        assign differ      = sync2_q[gi] ^ level_q[gi];
        assign at_term     = (cnt_q[gi] == TERM);
        assign level_d[gi] = (differ && at_term) ? sync2_q[gi] : level_q[gi];
        assign cnt_d[gi]   = (differ && !at_term) ? (cnt_q[gi] + CW'(1)) : '0;

        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_q[gi] <= '0;
            end else begin
                cnt_q[gi] <= cnt_d[gi];
            end
        end
    end

    if (WIDTH < 32) begin : g_unused_wdata
        logic unused_wdata_bits;
        assign unused_wdata_bits = ^writedata[31:WIDTH];
    end

    assign wr_en    = chipselect & ~write_n;
    assign edge_set = EDGE_FALLING ? (level_prev_q & ~level_q) : (~level_prev_q & level_q);

    always_comb begin
        mask_d = mask_q;
        ecap_d = ecap_q;
        if (wr_en && (address == ADDR_IRQMASK)) begin
            mask_d = writedata[WIDTH-1:0];
        end
        if (wr_en && (address == ADDR_EDGECAP)) begin
            ecap_d = ecap_q & ~writedata[WIDTH-1:0];
        end
        // A capture arriving in the same cycle as its clear must not be lost.
        ecap_d = ecap_d | edge_set;
        irq_d  = |(ecap_q & mask_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q      <= RESET_LEVEL;
            sync2_q      <= RESET_LEVEL;
            level_q      <= RESET_LEVEL;
            level_prev_q <= RESET_LEVEL;
            mask_q       <= '0;
            ecap_q       <= '0;
            irq_q        <= 1'b0;
        end else begin
            sync1_q      <= in_port;
            sync2_q      <= sync1_q;
            level_q      <= level_d;
            level_prev_q <= level_q;
            mask_q       <= mask_d;
            ecap_q       <= ecap_d;
            irq_q        <= irq_d;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:    readdata = 32'(level_q);
            ADDR_IRQMASK: readdata = 32'(mask_q);
            ADDR_EDGECAP: readdata = 32'(ecap_q);
            default:      readdata = '0;
        endcase
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_cpu_keys_in.sv
// Randomised bench for cpu_keys_in: a window-based reference model predicts every register read
// and the irq level; a negedge monitor pops predictions from a queue and compares.
module tb_cpu_keys_in;

    localparam int W  = 4;
    localparam int DC = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [W-1:0] in_port;
    logic        irq;

    always #5 clk = ~clk;

    cpu_keys_in #(
        .WIDTH(W), .DEBOUNCE_CYCLES(DC), .EDGE_FALLING(1'b1), .RESET_LEVEL(4'hF)
    ) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .in_port(in_port), .irq(irq)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0]  addr;
        logic [31:0] rd;
        logic        irq;
    } exp_t;
    exp_t exp_q[$];
    bit   rd_active = 1'b0;

    // Reference model: a bit's accepted level flips once the last DC synchronised samples all
    // disagree with it; a 1->0 flip is captured one edge later.
    logic [W-1:0] m_level, m_mask, m_ecap, m_fall_pend, m_p1, m_flips;
    logic         m_irq;
    logic [W-1:0] m_sync[$];
    int           m_dis;

    initial forever begin
        @(posedge clk);
        if (reset) begin
            m_level = 4'hF; m_mask = '0; m_ecap = '0; m_fall_pend = '0; m_irq = 1'b0;
            m_sync = {};
            m_sync.push_back(4'hF);
            m_p1 = 4'hF;
        end else begin
            m_irq = |(m_ecap & m_mask);
            if (chipselect && !write_n && address == 2'd3) m_ecap = m_ecap & ~writedata[W-1:0];
            m_ecap = m_ecap | m_fall_pend;
            if (chipselect && !write_n && address == 2'd2) m_mask = writedata[W-1:0];
            m_flips = '0;
            if (m_sync.size() >= DC) begin
                for (int b = 0; b < W; b++) begin
                    m_dis = 0;
                    for (int k = m_sync.size() - DC; k < m_sync.size(); k++)
                        if (m_sync[k][b] != m_level[b]) m_dis++;
                    if (m_dis == DC) m_flips[b] = 1'b1;
                end
            end
            m_fall_pend = m_flips & m_level;
            m_level     = m_level ^ m_flips;
            m_sync.push_back(m_p1);
            if (m_sync.size() > DC) void'(m_sync.pop_front());
            m_p1 = in_port;
        end
    end

    function automatic logic [31:0] model_reg(input logic [1:0] a);
        case (a)
            2'd0:    return 32'(m_level);
            2'd2:    return 32'(m_mask);
            2'd3:    return 32'(m_ecap);
            default: return 32'd0;
        endcase
    endfunction

    // Monitor: one prediction consumed per read cycle.
    exp_t e;
    initial forever begin
        @(negedge clk);
        if (rd_active) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL scoreboard_empty: read seen with no prediction queued");
            end else begin
                e = exp_q.pop_front();
                checks++;
                if (readdata !== e.rd) begin
                    errors++;
                    $display("FAIL read_addr%0d: got %h expected %h at %0t", e.addr, readdata, e.rd, $time);
                end
                checks++;
                if (irq !== e.irq) begin
                    errors++;
                    $display("FAIL irq: got %b expected %b at %0t", irq, e.irq, $time);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        chipselect = 1'b0; write_n = 1'b1; rd_active = 1'b0;
    endtask

    task automatic issue_read(input logic [1:0] a);
        exp_t x;
        chipselect = 1'b1; write_n = 1'b1; address = a;
        x.addr = a; x.rd = model_reg(a); x.irq = m_irq;
        exp_q.push_back(x);
        rd_active = 1'b1;
    endtask

    task automatic issue_write(input logic [1:0] a, input logic [31:0] d);
        rd_active = 1'b0;
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    endtask

    int  hold[W];
    int  op;
    int  wait_cnt;

    task automatic drive_pins();
        for (int b = 0; b < W; b++) begin
            if (hold[b] == 0) begin
                in_port[b] = 1'($urandom_range(0, 1));
                hold[b] = $urandom_range(1, 14);
            end else begin
                hold[b]--;
            end
        end
    endtask

    initial begin
        reset = 1'b1; in_port = 4'hF; address = 2'd0; writedata = '0;
        bus_idle();
        for (int b = 0; b < W; b++) hold[b] = 0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int a = 0; a < 4; a++) begin
            issue_read(2'(a));
            tick();
        end

        for (int cyc = 0; cyc < 3000; cyc++) begin
            drive_pins();
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 149) == 0) reset = 1'b1;
            op = $urandom_range(0, 11);
            if (op == 0)      issue_write(2'd2, $urandom);
            else if (op == 1) issue_write(2'd3, $urandom);
            else              issue_read(2'($urandom_range(0, 3)));
            tick();
        end

        // Collide a W1C of bit 2 with the cycle in which bit 2's falling edge is captured.
        reset = 1'b0; in_port = 4'hF;
        bus_idle();
        repeat (2 * DC + 4) tick();
        in_port[2] = 1'b0;
        wait_cnt = 0;
        while (!m_fall_pend[2] && wait_cnt < 200) begin
            tick();
            wait_cnt++;
        end
        if (!m_fall_pend[2]) begin
            checks++; errors++;
            $display("FAIL collision_timeout: bit2 edge not seen within %0d cycles", wait_cnt);
        end else begin
            issue_write(2'd3, 32'h4);
            tick();
            issue_read(2'd3);
            @(negedge clk);
            checks++;
            if (readdata[2] !== 1'b1) begin
                errors++;
                $display("FAIL collision_set_wins: EDGECAP[2] got %b expected 1", readdata[2]);
            end
            tick();
        end

        bus_idle();
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d predictions left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
